div_issue_unit: RTL and testbench
=================================

Name: div_issue_unit

Overview:
EX-stage front end for the multi-cycle divider. It accepts decoded DIV/REM-family operations from the ID/EX register through a valid/ready handshake. It launches the divider, stalls the pipeline until the result is available, and hands the result to EX/MEM through a second valid/ready handshake. A one-entry last-result cache returns a repeated identical operation (same op, same operands) without re-running the divider. Pipeline flush can kill an operation at any point, including while the divider is running.

Parameters:
TAG_W, 5, width of destination-register tag carried alongside the op
CACHE_EN, 1, 1 enables the last-result cache; 0 forces every op to the divider

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
req_valid  in  1  operation offered by ID/EX
req_ready  out  1  unit can accept an operation
req_op  in  3  div_type encoding: 100 DIV, 101 DIVU, 110 REM, 111 REMU, 000 DIVW, 001 DIVUW, 010 REMW, 011 REMUW
req_a  in  64  dividend
req_b  in  64  divisor
req_tag  in  TAG_W  destination tag
resp_valid  out  1  result available
resp_ready  in  1  EX/MEM consumes result
resp_data  out  64  result
resp_tag  out  TAG_W  tag of the result
stall  out  1  pipeline freeze request
flush  in  1  kill in-flight operation
cache_hit  out  1  one-cycle pulse on each cache hit (perf counter)
div_start  out  1  divider start pulse
div_dividend  out  64  divider operand
div_divisor  out  64  divider operand
div_type  out  3  divider op
div_result  in  64  divider result
div_done  in  1  divider done; may remain high up to 2 consecutive cycles
div_busy  in  1  divider computing

Behaviour:
- Reset, sampled on posedge clk: state=IDLE; resp_valid=0; div_start=0; cache_hit=0; cache_valid=0; done_q=0; operand/result registers = 0. After reset: req_ready=1, stall=0.
- done_q is div_done delayed one cycle. done_rise = div_done & !done_q. Results are captured only on done_rise, so a 2-cycle done is captured once.
- States: IDLE, ISSUE, WAIT, RESP, DRAIN.
- IDLE:
  - req_ready=1.
  - Accept when req_valid & !flush. Latch op, a, b and tag.
  - Cache hit = CACHE_EN & cache_valid & op/a/b all equal the cached values.
  - On hit: load resp_data from the cache, pulse cache_hit, go to RESP. The response appears the cycle after acceptance.
  - On miss: go to ISSUE.
- ISSUE:
  - div_start = !div_busy & !div_done & !flush (combinational; one cycle only). Go to WAIT when div_start=1.
  - flush: go to IDLE with no start issued.
  - div_dividend, div_divisor and div_type are driven from the latched registers. They stay stable from ISSUE until capture.
- WAIT:
  - On done_rise: resp_data=div_result, then go to RESP.
  - The cache is loaded with {op, a, b, div_result} at the same time, and cache_valid=1.
  - flush without done_rise: go to DRAIN.
  - flush together with done_rise: go to DRAIN; the result is dropped and the cache is not updated.
- DRAIN:
  - req_ready=0.
  - On done_rise: discard the result, leave the cache unchanged, go to IDLE.
- RESP:
  - resp_valid=1. resp_data and resp_tag hold stable until resp_ready.
  - resp_ready: go to IDLE. No same-cycle re-accept; req_ready=0 in RESP.
  - flush: drop the response and go to IDLE; resp_ready is ignored.
- req_ready=1 only in IDLE.
- stall = (req_valid & !req_ready) | ISSUE | WAIT | (RESP & !resp_ready). stall is combinational.
- Divide-by-zero and overflow results come from the divider unchanged. The unit does no special-case arithmetic.
- reset mid-operation: the unit returns to IDLE. The divider shares the same reset.

Test Plan:
- DIVU, a=100, b=7, tag=3, divider model done after 66 cycles -> exactly one div_start pulse with 100/7/101; resp_valid with resp_data=14 and resp_tag=3; stall high from acceptance until resp_ready.
- Repeat DIVU 100/7, tag=4 -> no div_start; cache_hit pulses; resp_valid the next cycle with resp_data=14 and resp_tag=4.
- REM 100/7 (op 110) -> cache miss, divider issued, resp_data=2. A following DIVU 100/7 then misses and re-issues.
- DIVW a=0x5, b=0 with model done held 2 cycles -> single capture of resp_data=0xFFFFFFFFFFFFFFFF. No new div_start while div_done=1.
- flush 10 cycles into WAIT -> resp_valid never asserts; req_ready=0 until done_rise; the cache still holds the prior entry. The next request issues normally.
- resp_ready=0 for 3 cycles in RESP -> resp_data and resp_tag stable, stall=1, req_ready=0. resp_ready=1 -> IDLE the next cycle.

Source files
------------

// File: rtl/div_issue_if.sv
// Request/response handshake bundle between the ID/EX and EX/MEM pipeline
// registers and the divider issue unit.
interface div_issue_if #(
    parameter int TAG_W = 5
);
    logic             req_valid;
    logic             req_ready;
    logic [2:0]       req_op;
    logic [63:0]      req_a;
    logic [63:0]      req_b;
    logic [TAG_W-1:0] req_tag;

    logic             resp_valid;
    logic             resp_ready;
    logic [63:0]      resp_data;
    logic [TAG_W-1:0] resp_tag;

    // Pipeline side: offers operations and consumes results.
    modport master (
        output req_valid, req_op, req_a, req_b, req_tag, resp_ready,
        input  req_ready, resp_valid, resp_data, resp_tag
    );

    // Issue-unit side.
    modport slave (
        input  req_valid, req_op, req_a, req_b, req_tag, resp_ready,
        output req_ready, resp_valid, resp_data, resp_tag
    );
endinterface

// File: rtl/div_issue_unit.sv
// EX-stage front end for the multi-cycle divider: accepts an op, launches the divider,
// stalls the pipe until the result returns, and replays an identical repeat from a one-entry cache.
module div_issue_unit #(
    parameter int TAG_W    = 5,
    parameter int CACHE_EN = 1
) (
    input  logic         clk,
    input  logic         reset,
    div_issue_if.slave   bus,
    output logic         stall,
    input  logic         flush,
    output logic         cache_hit,
    output logic         div_start,
    output logic [63:0]  div_dividend,
    output logic [63:0]  div_divisor,
    output logic [2:0]   div_type,
    input  logic [63:0]  div_result,
    input  logic         div_done,
    input  logic         div_busy
);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP,
        DRAIN
    } state_t;

    state_t state, next_state;

    logic             done_q;
    logic             done_rise;
    logic [2:0]       op_q;
    logic [63:0]      a_q;
    logic [63:0]      b_q;
    logic [TAG_W-1:0] tag_q;
    logic [63:0]      resp_data_q;

    logic             cache_valid;
    logic [2:0]       cache_op;
    logic [63:0]      cache_a;
    logic [63:0]      cache_b;
    logic [63:0]      cache_res;

    logic             accept;
    logic             hit_now;
    logic             capture;

    // The divider may hold done for two cycles; only its rising edge counts as a result.
    assign done_rise = div_done & ~done_q;

    assign hit_now = (CACHE_EN != 0) && cache_valid &&
                     (bus.req_op == cache_op) &&
                     (bus.req_a  == cache_a)  &&
                     (bus.req_b  == cache_b);

    always_comb begin
        next_state = state;
        accept     = 1'b0;
        capture    = 1'b0;
        div_start  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.req_valid && !flush) begin
                    accept     = 1'b1;
                    next_state = hit_now ? RESP : ISSUE;
                end
            end
            ISSUE: begin
                if (flush) begin
                    next_state = IDLE;
                end else if (!div_busy && !div_done) begin
                    div_start  = 1'b1;
                    next_state = WAIT;
                end
            end
            WAIT: begin
                // A flush coinciding with the result still drops it and drains.
                if (flush) begin
                    next_state = DRAIN;
                end else if (done_rise) begin
                    capture    = 1'b1;
                    next_state = RESP;
                end
            end
            RESP: begin
                if (flush || bus.resp_ready) begin
                    next_state = IDLE;
                end
            end
            DRAIN: begin
                if (done_rise) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            done_q      <= 1'b0;
            cache_hit   <= 1'b0;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            tag_q       <= '0;
            resp_data_q <= '0;
            cache_valid <= 1'b0;
            cache_op    <= '0;
            cache_a     <= '0;
            cache_b     <= '0;
            cache_res   <= '0;
        end else begin
            state     <= next_state;
            done_q    <= div_done;
            cache_hit <= accept && hit_now;
            if (accept) begin
                op_q  <= bus.req_op;
                a_q   <= bus.req_a;
                b_q   <= bus.req_b;
                tag_q <= bus.req_tag;
                if (hit_now) begin
                    resp_data_q <= cache_res;
                end
            end
            if (capture) begin
                resp_data_q <= div_result;
                cache_valid <= 1'b1;
                cache_op    <= op_q;
                cache_a     <= a_q;
                cache_b     <= b_q;
                cache_res   <= div_result;
            end
        end
    end

    assign bus.req_ready  = (state == IDLE);
    assign bus.resp_valid = (state == RESP);
    assign bus.resp_data  = resp_data_q;
    assign bus.resp_tag   = tag_q;

    assign div_dividend = a_q;
    assign div_divisor  = b_q;
    assign div_type     = op_q;

    assign stall = (bus.req_valid && !bus.req_ready) ||
                   (state == ISSUE) || (state == WAIT) ||
                   ((state == RESP) && !bus.resp_ready);

endmodule

// File: tb/tb_div_issue_unit.sv
// Directed bench for div_issue_unit with a behavioural divider whose latency,
// done-pulse length and result are set per vector.
module tb_div_issue_unit;

    localparam int TAG_W = 5;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        flush;
    logic        cache_hit;
    logic        div_start;
    logic [63:0] div_dividend;
    logic [63:0] div_divisor;
    logic [2:0]  div_type;
    logic [63:0] div_result;
    logic        div_done;
    logic        div_busy;

    div_issue_if #(.TAG_W(TAG_W)) bus ();

    div_issue_unit #(.TAG_W(TAG_W), .CACHE_EN(1)) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus.slave),
        .stall        (stall),
        .flush        (flush),
        .cache_hit    (cache_hit),
        .div_start    (div_start),
        .div_dividend (div_dividend),
        .div_divisor  (div_divisor),
        .div_type     (div_type),
        .div_result   (div_result),
        .div_done     (div_done),
        .div_busy     (div_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          model_latency;
    int          model_done_len;
    logic [63:0] model_result;
    int          cnt;
    int          done_left;
    int          start_count;
    int          starts_during_done;
    logic [63:0] cap_a;
    logic [63:0] cap_b;
    logic [2:0]  cap_type;

    // Divider model: busy for model_latency cycles after a start, then done for model_done_len cycles.
    always @(posedge clk) begin
        if (reset) begin
            div_busy           <= 1'b0;
            cnt                <= 0;
            done_left          <= 0;
            start_count        <= 0;
            starts_during_done <= 0;
            cap_a              <= '0;
            cap_b              <= '0;
            cap_type           <= '0;
        end else begin
            if (done_left > 0) done_left <= done_left - 1;
            if (div_start && div_done) starts_during_done <= starts_during_done + 1;
            if (div_start && !div_busy) begin
                div_busy    <= 1'b1;
                cnt         <= model_latency;
                start_count <= start_count + 1;
                cap_a       <= div_dividend;
                cap_b       <= div_divisor;
                cap_type    <= div_type;
            end else if (div_busy) begin
                if (cnt <= 1) begin
                    div_busy  <= 1'b0;
                    done_left <= model_done_len;
                end else begin
                    cnt <= cnt - 1;
                end
            end
        end
    end

    assign div_done   = (done_left > 0);
    assign div_result = model_result;

    int checks;
    int failures;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Offers one op at a negedge; it is accepted on the following posedge.
    task automatic applyStimulus(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                                 input logic [TAG_W-1:0] tag);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_a     = a;
        bus.req_b     = b;
        bus.req_tag   = tag;
        #1;
        checkOutput("accept_ready", bus.req_ready, 1'b1);
        @(negedge clk);
        bus.req_valid = 1'b0;
    endtask

    task automatic waitResp(input int limit, output int stall_drops);
        stall_drops = 0;
        for (int i = 0; i < limit; i++) begin
            if (bus.resp_valid) break;
            if (!stall) stall_drops++;
            @(negedge clk);
        end
    endtask

    task automatic releaseResp();
        bus.resp_ready = 1'b1;
        #1;
        checkOutput("release_stall", stall, 1'b0);
        @(negedge clk);
        bus.resp_ready = 1'b0;
        checkOutput("release_idle_ready", bus.req_ready, 1'b1);
        checkOutput("release_resp_valid", bus.resp_valid, 1'b0);
    endtask

    int base;
    int drops;
    int viol;

    initial begin
        checks            = 0;
        failures          = 0;
        reset             = 1'b1;
        flush             = 1'b0;
        bus.req_valid     = 1'b0;
        bus.req_op        = '0;
        bus.req_a         = '0;
        bus.req_b         = '0;
        bus.req_tag       = '0;
        bus.resp_ready    = 1'b0;
        model_latency     = 66;
        model_done_len    = 1;
        model_result      = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        checkOutput("rst_req_ready", bus.req_ready, 1'b1);
        checkOutput("rst_stall", stall, 1'b0);
        checkOutput("rst_resp_valid", bus.resp_valid, 1'b0);
        checkOutput("rst_div_start", div_start, 1'b0);
        checkOutput("rst_cache_hit", cache_hit, 1'b0);

        // DIVU 100/7 through the divider
        base = start_count; model_latency = 66; model_done_len = 1; model_result = 64'd14;
        applyStimulus(3'b101, 64'd100, 64'd7, 5'd3);
        waitResp(200, drops);
        checkOutput("t1_resp_valid", bus.resp_valid, 1'b1);
        checkOutput("t1_resp_data", bus.resp_data, 64'd14);
        checkOutput("t1_resp_tag", bus.resp_tag, 64'd3);
        checkOutput("t1_starts", start_count - base, 64'd1);
        checkOutput("t1_dividend", cap_a, 64'd100);
        checkOutput("t1_divisor", cap_b, 64'd7);
        checkOutput("t1_type", cap_type, 64'd5);
        checkOutput("t1_stall_drops", drops, 64'd0);
        checkOutput("t1_stall_resp", stall, 1'b1);
        checkOutput("t1_no_hit", cache_hit, 1'b0);
        releaseResp();

        // Identical DIVU 100/7 is served from the cache
        base = start_count;
        applyStimulus(3'b101, 64'd100, 64'd7, 5'd4);
        checkOutput("t2_resp_valid", bus.resp_valid, 1'b1);
        checkOutput("t2_cache_hit", cache_hit, 1'b1);
        checkOutput("t2_resp_data", bus.resp_data, 64'd14);
        checkOutput("t2_resp_tag", bus.resp_tag, 64'd4);
        @(negedge clk);
        checkOutput("t2_hit_pulse", cache_hit, 1'b0);
        checkOutput("t2_starts", start_count - base, 64'd0);
        releaseResp();

        // REM 100/7 misses; then DIVU 100/7 misses again
        base = start_count; model_latency = 10; model_result = 64'd2;
        applyStimulus(3'b110, 64'd100, 64'd7, 5'd5);
        checkOutput("t3_miss", bus.resp_valid, 1'b0);
        waitResp(100, drops);
        checkOutput("t3_resp_data", bus.resp_data, 64'd2);
        checkOutput("t3_starts", start_count - base, 64'd1);
        checkOutput("t3_type", cap_type, 64'd6);
        releaseResp();
        base = start_count; model_latency = 8; model_result = 64'd14;
        applyStimulus(3'b101, 64'd100, 64'd7, 5'd6);
        checkOutput("t3b_miss", bus.resp_valid, 1'b0);
        waitResp(100, drops);
        checkOutput("t3b_resp_data", bus.resp_data, 64'd14);
        checkOutput("t3b_starts", start_count - base, 64'd1);
        releaseResp();

        // DIVW 5/0 with a two-cycle done pulse
        base = start_count; model_latency = 5; model_done_len = 2; model_result = 64'hFFFF_FFFF_FFFF_FFFF;
        applyStimulus(3'b000, 64'd5, 64'd0, 5'd8);
        waitResp(100, drops);
        checkOutput("t4_resp_data", bus.resp_data, 64'hFFFF_FFFF_FFFF_FFFF);
        @(negedge clk);
        checkOutput("t4_hold_valid", bus.resp_valid, 1'b1);
        checkOutput("t4_hold_data", bus.resp_data, 64'hFFFF_FFFF_FFFF_FFFF);
        checkOutput("t4_starts", start_count - base, 64'd1);
        releaseResp();
        model_done_len = 1;

        // Flush 10 cycles into WAIT, then drain
        model_latency = 30; model_result = 64'd22;
        applyStimulus(3'b101, 64'd200, 64'd9, 5'd9);
        repeat (10) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        viol = 0;
        for (int i = 0; i < 100; i++) begin
            if (div_done) break;
            if (bus.req_ready || bus.resp_valid) viol++;
            @(negedge clk);
        end
        checkOutput("t5_done_seen", div_done, 1'b1);
        checkOutput("t5_drain_viol", viol, 64'd0);
        @(negedge clk);
        checkOutput("t5_idle_ready", bus.req_ready, 1'b1);
        checkOutput("t5_no_resp", bus.resp_valid, 1'b0);
        base = start_count;
        applyStimulus(3'b000, 64'd5, 64'd0, 5'd10);
        checkOutput("t5_prior_hit", cache_hit, 1'b1);
        checkOutput("t5_prior_data", bus.resp_data, 64'hFFFF_FFFF_FFFF_FFFF);
        checkOutput("t5_prior_starts", start_count - base, 64'd0);
        releaseResp();
        base = start_count; model_latency = 12;
        applyStimulus(3'b101, 64'd200, 64'd9, 5'd11);
        checkOutput("t5_reissue_miss", bus.resp_valid, 1'b0);
        waitResp(100, drops);
        checkOutput("t5_reissue_data", bus.resp_data, 64'd22);
        checkOutput("t5_reissue_starts", start_count - base, 64'd1);

        // Hold the response with resp_ready low for three cycles
        for (int i = 0; i < 3; i++) begin
            checkOutput("t6_hold_data", bus.resp_data, 64'd22);
            checkOutput("t6_hold_tag", bus.resp_tag, 64'd11);
            checkOutput("t6_hold_stall", stall, 1'b1);
            checkOutput("t6_hold_ready", bus.req_ready, 1'b0);
            @(negedge clk);
        end
        releaseResp();

        // Flush while a cached response is pending drops it
        applyStimulus(3'b101, 64'd200, 64'd9, 5'd12);
        checkOutput("t7_hit_valid", bus.resp_valid, 1'b1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        checkOutput("t7_dropped", bus.resp_valid, 1'b0);
        checkOutput("t7_idle_ready", bus.req_ready, 1'b1);

        checkOutput("no_start_during_done", starts_during_done, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
